// File: rtl/pc_unit.sv
// Program counter with next-PC select and return-address stack.
// Define PC_RAS_EN for the full RAS; otherwise a single link register is used.
module pc_unit #(
  parameter int ADDR_W = 32,
  parameter int RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic [1:0]        pc_src,
  input  logic              push_ret,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_udf
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] top_val;
  logic              hold;
  logic              sel_seq;
  logic              sel_jmp;
  logic              sel_br;
  logic              sel_ret;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + ADDR_W'(4);

  assign sel_seq = (pc_src == 2'b00);
  assign sel_jmp = (pc_src == 2'b01);
  assign sel_br  = (pc_src == 2'b10);
  assign sel_ret = (pc_src == 2'b11);

  // pc_src is only decoded under pc_write so an idle X is harmless
  always_comb begin
    tgt = pc_plus4;
    if (pc_write) begin
      unique case (1'b1)
        sel_seq: tgt = pc_plus4;
        sel_jmp: tgt = jump_target;
        sel_br:  tgt = branch_target;
        sel_ret: tgt = top_val;
        default: tgt = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (pc_write && !hold) begin
      pc_q <= {tgt[ADDR_W-1:2], 2'b00};
    end
  end

`ifdef PC_RAS_EN
  localparam int IW = $clog2(RAS_DEPTH);
  localparam int PW = IW + 1;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     cnt_q;
  logic [PW-1:0]     cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              udf_q;
  logic              udf_d;
  logic              we;
  logic [IW-1:0]     widx;
  logic [IW-1:0]     top;

  assign top       = IW'(cnt_q - PW'(1));
  assign top_val   = ras[top];
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == PW'(RAS_DEPTH));
  assign ras_ovf   = ovf_q;
  assign ras_udf   = udf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    we    = 1'b0;
    widx  = cnt_q[IW-1:0];
    hold  = 1'b0;
    if (pc_write) begin
      if (sel_ret) begin
        if (ras_empty) begin
          hold  = 1'b1;
          udf_d = 1'b1;
          if (push_ret) begin
            we    = 1'b1;
            widx  = '0;
            cnt_d = PW'(1);
          end
        end else if (push_ret) begin
          // pop-with-push: swap the top slot in place
          we   = 1'b1;
          widx = top;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end else if (push_ret) begin
        if (ras_full) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          cnt_d = cnt_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (we) begin
        ras[widx] <= pc_plus4;
      end
    end
  end
`else
  logic [ADDR_W-1:0] link_q;

  assign top_val   = link_q;
  assign hold      = 1'b0;
  assign ras_empty = 1'b0;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_udf   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= '0;
    end else if (pc_write && push_ret) begin
      link_q <= pc_plus4;
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_pc_unit;
  localparam int AW = 32;
  localparam int DEPTH = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        push_ret = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_udf;

  pc_unit #(
    .ADDR_W(AW),
    .RAS_DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .push_ret(push_ret),
    .jump_target(jump_target),
    .branch_target(branch_target),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_ovf(ras_ovf),
    .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic [31:0] mpc;
  logic [31:0] mlink;
  logic [31:0] mq[$];
  bit          movf;
  bit          mudf;

  typedef struct {
    bit          pw;
    logic [1:0]  src;
    bit          psh;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [31:0] exp_pc;
    bit          exp_empty;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mpc = RST_PC;
    mlink = '0;
    mq.delete();
    movf = 1'b0;
    mudf = 1'b0;
  endfunction

  function automatic void model_step(bit pw, logic [1:0] src, bit psh,
                                     logic [31:0] jt, logic [31:0] bt);
    logic [31:0] p4;
    logic [31:0] nxt;
    if (!pw) return;
    p4 = mpc + 32'd4;
    case (src)
      2'b00: nxt = p4;
      2'b01: nxt = jt;
      2'b10: nxt = bt;
      default: nxt = '0;
    endcase
`ifdef PC_RAS_EN
    if (src == 2'b11) begin
      if (mq.size() == 0) begin
        mudf = 1'b1;
        if (psh) mq.push_back(p4);
      end else begin
        nxt = mq.pop_back();
        mpc = nxt & ~32'h3;
        if (psh) mq.push_back(p4);
      end
    end else begin
      mpc = nxt & ~32'h3;
      if (psh) begin
        if (mq.size() == DEPTH) movf = 1'b1;
        else mq.push_back(p4);
      end
    end
`else
    if (src == 2'b11) nxt = mlink;
    mpc = nxt & ~32'h3;
    if (psh) mlink = p4;
`endif
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".pc"}, pc, mpc);
    chk({tag, ".pc_plus4"}, pc_plus4, mpc + 32'd4);
`ifdef PC_RAS_EN
    chk({tag, ".empty"}, 32'(ras_empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(ras_full), 32'(mq.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(ras_ovf), 32'(movf));
    chk({tag, ".udf"}, 32'(ras_udf), 32'(mudf));
`else
    chk({tag, ".flags"}, {28'd0, ras_empty, ras_full, ras_ovf, ras_udf}, 32'd0);
`endif
  endtask

  task automatic step(bit pw, logic [1:0] src, bit psh,
                      logic [31:0] jt, logic [31:0] bt, string tag);
    @(negedge clk);
    pc_write = pw;
    pc_src = src;
    push_ret = psh;
    jump_target = jt;
    branch_target = bt;
    @(posedge clk);
    #1;
    model_step(pw, src, psh, jt, bt);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    chk("reset.pc_const", pc, RST_PC);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   32'h0,   32'h4,   1'b1});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   32'h0,   32'h8,   1'b1});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   32'h0,   32'hC,   1'b1});
    tbl.push_back('{1'b1, 2'b01, 1'b1, 32'h100, 32'h0,   32'h100, 1'b0});
    tbl.push_back('{1'b1, 2'b11, 1'b0, 32'h0,   32'h0,   32'h10,  1'b1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 2'bxx, 1'b1, 32'h44, 32'h88, 32'h10, 1'b1});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 32'h0,   32'h203, 32'h200, 1'b1});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b1});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 32'h0,   32'h0,   32'h0,   1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].pw, tbl[i].src, tbl[i].psh, tbl[i].jt, tbl[i].bt, "tbl");
      chk("tbl.exp_pc", pc, tbl[i].exp_pc);
      chk("tbl.exp_empty", 32'(ras_empty), 32'(tbl[i].exp_empty & RAS_ON));
    end

    for (int i = 0; i < 9; i++)
      step(1'b1, 2'b01, 1'b1, 32'h1000 * (i + 1), 32'h0, "jal");
`ifdef PC_RAS_EN
    chk("jal9.full", 32'(ras_full), 32'd1);
    chk("jal9.ovf", 32'(ras_ovf), 32'd1);
`endif
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, "pop");
`ifdef PC_RAS_EN
      chk("pop.lifo", pc, (k < 7) ? 32'h1000 * (7 - k) + 32'd4 : 32'h4);
`else
      chk("pop.link", pc, 32'h8004);
`endif
    end
    step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, "pop9");
`ifdef PC_RAS_EN
    chk("pop9.hold", pc, 32'h4);
    chk("pop9.udf", 32'(ras_udf), 32'd1);
`else
    chk("pop9.link", pc, 32'h8004);
`endif

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc", pc, RST_PC);
    chk("async_rst.flags", {28'd0, ras_empty, ras_full, ras_ovf, ras_udf},
        {28'd0, RAS_ON, 3'b000});
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 2'b11, 1'b1, 32'h0, 32'h0, "popush_empty");
    chk("popush_empty.pc", pc, 32'h0);
    step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, "pop_after");
    chk("pop_after.pc", pc, 32'h4);

`ifndef PC_RAS_EN
    step(1'b1, 2'b01, 1'b1, 32'h300, 32'h0, "lnk_jal1");
    step(1'b1, 2'b01, 1'b1, 32'h400, 32'h0, "lnk_jal2");
    step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, "lnk_ret1");
    chk("lnk_ret1.pc", pc, 32'h304);
    step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, "lnk_ret2");
    chk("lnk_ret2.pc", pc, 32'h304);
`endif

    for (int n = 0; n < 400; n++) begin
      bit          pw;
      logic [1:0]  src;
      bit          psh;
      pw  = ($urandom_range(0, 3) != 0);
      src = 2'($urandom_range(0, 3));
      psh = ($urandom_range(0, 9) < 4);
      if (!pw && $urandom_range(0, 1) == 1) src = 2'bxx;
      step(pw, src, psh, $urandom(), $urandom(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
